// File: rtl/ram_2p_fifo_pkg.sv
// Shared helpers for the ram_2p-backed FIFO: pointer sizing and modulo-DEPTH
// pointer advance, so DEPTH need not be a power of two.
package ram_2p_fifo_pkg;

  // Bits needed to address n entries; at least 1 so a 2-entry RAM still has an address bit.
  function automatic int log2(input int unsigned n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ram_2p.sv
// Simple dual-port RAM: write port A, registered read port B.
// doutb holds its last value while enb is low; the FIFO depends on that.
module ram_2p #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clka,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [WIDTH-1:0]      dina,
  input  logic                  clkb,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [WIDTH-1:0]      doutb
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (enb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/ram_2p_fifo.sv
// First-word-fall-through FIFO on a single ram_2p: push writes the RAM, a
// prefetch scheduler keeps the head word loaded on the RAM read port.
module ram_2p_fifo
  import ram_2p_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = log2(DEPTH),
  parameter int AFULL      = DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH + 1)'(AFULL);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  head_vld;
  logic                  wr_go;
  logic                  rd_go;
  logic [ADDR_WIDTH:0]   ram_cnt_nxt;

  // Both ports are gated by rst so a push or pop in the reset cycle never touches the RAM.
  always_comb begin
    wr_go       = push & ~full & ~rst;
    rd_go       = (ram_cnt != '0) & (~head_vld | pop) & ~rst;
    ram_cnt_nxt = ram_cnt + (ADDR_WIDTH + 1)'(wr_go) - (ADDR_WIDTH + 1)'(rd_go);
  end

  assign full        = (ram_cnt == DEPTH_C);
  assign empty       = ~head_vld;
  assign count       = ram_cnt + (ADDR_WIDTH + 1)'(head_vld);
  assign almost_full = (count >= AFULL_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      head_vld <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (wr_go) wptr <= ADDR_WIDTH'(wrap_inc(32'(wptr), DEPTH));
      if (rd_go) rptr <= ADDR_WIDTH'(wrap_inc(32'(rptr), DEPTH));
      ram_cnt <= ram_cnt_nxt;
      if (rd_go)    head_vld <= 1'b1;
      else if (pop) head_vld <= 1'b0;
      if (push && full)    ovf <= 1'b1;
      if (pop && !head_vld) udf <= 1'b1;
    end
  end

  // The head word is the RAM read register itself; it holds between prefetches.
  ram_2p #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clka (clk),
    .ena  (wr_go),
    .wea  (wr_go),
    .addra(wptr),
    .dina (din),
    .clkb (clk),
    .enb  (rd_go),
    .addrb(rptr),
    .doutb(dout)
  );

endmodule

// File: tb/tb_ram_2p_fifo.sv
// Bench for ram_2p_fifo: DEPTH=4 and DEPTH=3 instances share stimulus and are
// checked against a queue-style reference model of RAM contents plus head word.
module tb_ram_2p_fifo;

  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic [7:0] din;

  logic [7:0] dout_o  [2];
  logic       empty_o [2];
  logic       full_o  [2];
  logic       af_o    [2];
  logic       ovf_o   [2];
  logic       udf_o   [2];
  logic [2:0] count_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words waiting in RAM (oldest first) plus the presented head.
  logic [7:0] mdata [2][8];
  int         msize [2];
  logic       mhv   [2];
  logic [7:0] mhead [2];
  logic       movf  [2];
  logic       mudf  [2];

  always #5 clk = ~clk;

  ram_2p_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .push(push), .din(din), .full(full_o[0]),
    .almost_full(af_o[0]), .pop(pop), .dout(dout_o[0]), .empty(empty_o[0]),
    .count(count_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0])
  );

  ram_2p_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .push(push), .din(din), .full(full_o[1]),
    .almost_full(af_o[1]), .pop(pop), .dout(dout_o[1]), .empty(empty_o[1]),
    .count(count_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic logic [7:0] exp_status(input int k);
    int c;
    c = msize[k] + int'(mhv[k]);
    return {!mhv[k], msize[k] == dep(k), c >= dep(k) - 2, movf[k], mudf[k], 3'(c)};
  endfunction

  // One clock with the given inputs; the model advances on the same edge.
  task automatic cycle(input logic r, input logic p, input logic [7:0] d, input logic q);
    logic acc, pres;
    rst = r; push = p; din = d; pop = q;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        msize[k] = 0; mhv[k] = 1'b0; movf[k] = 1'b0; mudf[k] = 1'b0;
      end else begin
        acc = p && (msize[k] < dep(k));
        if (p && !acc) movf[k] = 1'b1;
        if (q && !mhv[k]) mudf[k] = 1'b1;
        pres = (msize[k] > 0) && (!mhv[k] || q);
        if (pres) begin
          mhead[k] = mdata[k][0];
          for (int i = 0; i < 7; i++) mdata[k][i] = mdata[k][i+1];
          msize[k]--;
          mhv[k] = 1'b1;
        end else if (q) begin
          mhv[k] = 1'b0;
        end
        if (acc) begin
          mdata[k][msize[k]] = d;
          msize[k]++;
        end
      end
    end
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (empty_o[k] !== 1'b1) begin n_fail++; $display("FAIL reset_empty dut%0d: got %b want 1", k, empty_o[k]); end
      n_checks++;
      if (full_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_full dut%0d: got %b want 0", k, full_o[k]); end
      n_checks++;
      if (count_o[k] !== 3'd0) begin n_fail++; $display("FAIL reset_count dut%0d: got %0d want 0", k, count_o[k]); end
      n_checks++;
      if ({ovf_o[k], udf_o[k], af_o[k]} !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags dut%0d: got ovf/udf/af=%b%b%b want 000", k, ovf_o[k], udf_o[k], af_o[k]);
      end
    end
  endtask

  task automatic test_single_push;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h11, 1'b0);
    n_checks++;
    if (empty_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_latency: got empty=%b want 1 one cycle after push", empty_o[0]); end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({empty_o[k], dout_o[k], count_o[k]} !== {1'b0, 8'h11, 3'd1}) begin
        n_fail++; $display("FAIL single_head dut%0d: got empty=%b dout=%h count=%0d want 0 11 1", k, empty_o[k], dout_o[k], count_o[k]);
      end
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({empty_o[0], count_o[0]} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL single_drain: got empty=%b count=%0d want 1 0", empty_o[0], count_o[0]);
    end
  endtask

  task automatic test_fill;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    n_checks++;
    if ({full_o[0], count_o[0], ovf_o[0]} !== {1'b1, 3'd5, 1'b0}) begin
      n_fail++; $display("FAIL fill_full4: got full=%b count=%0d ovf=%b want 1 5 0", full_o[0], count_o[0], ovf_o[0]);
    end
    n_checks++;
    if ({full_o[1], count_o[1], ovf_o[1]} !== {1'b1, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL fill_full3: got full=%b count=%0d ovf=%b want 1 4 1", full_o[1], count_o[1], ovf_o[1]);
    end
    cycle(1'b0, 1'b1, 8'h06, 1'b0);
    n_checks++;
    if ({ovf_o[0], count_o[0]} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL fill_ovf: got ovf=%b count=%0d want 1 5", ovf_o[0], count_o[0]);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({empty_o[0], dout_o[0]} !== {1'b0, 8'(i + 1)}) begin
        n_fail++; $display("FAIL fill_order pop%0d: got empty=%b dout=%h want 0 %h", i, empty_o[0], dout_o[0], 8'(i + 1));
      end
      if (mhv[1]) begin
        n_checks++;
        if (dout_o[1] !== mhead[1]) begin n_fail++; $display("FAIL fill_order3 pop%0d: got %h want %h", i, dout_o[1], mhead[1]); end
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    n_checks++;
    if ({empty_o[0], count_o[0], full_o[0]} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL fill_drained: got empty=%b count=%0d full=%b want 1 0 0", empty_o[0], count_o[0], full_o[0]);
    end
  endtask

  task automatic test_wrap;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({empty_o[k], dout_o[k], count_o[k]} !== {1'b0, 8'(i), 3'd2}) begin
          n_fail++; $display("FAIL wrap_stream dut%0d step%0d: got empty=%b dout=%h count=%0d want 0 %h 2",
                             k, i, empty_o[k], dout_o[k], count_o[k], 8'(i));
        end
      end
      cycle(1'b0, 1'b1, 8'(i + 2), 1'b1);
    end
    n_checks++;
    if ({ovf_o[1], udf_o[1]} !== 2'b00) begin n_fail++; $display("FAIL wrap_flags: got ovf/udf=%b%b want 00", ovf_o[1], udf_o[1]); end
  endtask

  task automatic test_underflow;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({udf_o[k], ovf_o[k], empty_o[k], count_o[k]} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
        n_fail++; $display("FAIL underflow dut%0d: got udf=%b ovf=%b empty=%b count=%0d want 1 0 1 0",
                           k, udf_o[k], ovf_o[k], empty_o[k], count_o[k]);
      end
    end
  endtask

  task automatic test_reset_midop;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h31, 1'b0);
    cycle(1'b0, 1'b1, 8'h32, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0);
    n_checks++;
    if (count_o[0] !== 3'd3) begin n_fail++; $display("FAIL midop_fill: got count=%0d want 3", count_o[0]); end
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({empty_o[k], count_o[k]} !== {1'b1, 3'd0}) begin
        n_fail++; $display("FAIL midop_reset dut%0d: got empty=%b count=%0d want 1 0", k, empty_o[k], count_o[k]);
      end
    end
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    n_checks++;
    if (empty_o[0] !== 1'b1) begin n_fail++; $display("FAIL midop_latency: got empty=%b want 1", empty_o[0]); end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({empty_o[k], dout_o[k], count_o[k]} !== {1'b0, 8'hAA, 3'd1}) begin
        n_fail++; $display("FAIL midop_fresh dut%0d: got empty=%b dout=%h count=%0d want 0 aa 1", k, empty_o[k], dout_o[k], count_o[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] got, want;
    logic       r, p, q;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) == 0);
      if (n < 200)      begin p = ($urandom_range(0, 3) != 0); q = ($urandom_range(0, 3) == 0); end
      else if (n < 400) begin p = ($urandom_range(0, 3) == 0); q = ($urandom_range(0, 3) != 0); end
      else              begin p = $urandom_range(0, 1) != 0;   q = $urandom_range(0, 1) != 0;   end
      cycle(r, p, 8'($urandom), q);
      for (int k = 0; k < 2; k++) begin
        got  = {empty_o[k], full_o[k], af_o[k], ovf_o[k], udf_o[k], count_o[k]};
        want = exp_status(k);
        n_checks++;
        if (got !== want) begin
          n_fail++; $display("FAIL rand_status dut%0d cyc%0d: got %b want %b (empty,full,af,ovf,udf,count)", k, n, got, want);
        end
        if (mhv[k]) begin
          n_checks++;
          if (dout_o[k] !== mhead[k]) begin
            n_fail++; $display("FAIL rand_dout dut%0d cyc%0d: got %h want %h", k, n, dout_o[k], mhead[k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00;
    test_reset;
    test_single_push;
    test_fill;
    test_wrap;
    test_underflow;
    test_reset_midop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
